// File: rtl/mem_write_monitor.sv
// Pass/fail/timeout monitor snooping the MIPS data-memory write port.
// Optional MEM_WRITE_MONITOR_HIST_EN adds an 8-deep write history.
module mem_write_monitor #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int NSIG    = 4,
    parameter int CW      = 10,
    parameter int TIMEOUT = 512,
    parameter int ORDERED = 0,
    localparam int IW     = (NSIG > 1) ? $clog2(NSIG) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         memwrite,
    input  logic [AW-1:0]      dataadr,
    input  logic [DW-1:0]      writedata,
    input  logic [NSIG*AW-1:0] sig_addr,
    input  logic [NSIG*DW-1:0] sig_data,
    input  logic [NSIG-1:0]    sig_en,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
    output logic [IW-1:0]      match_idx,
    output logic [CW-1:0]      cycles,
    output logic [CW-1:0]      wr_count
`ifdef MEM_WRITE_MONITOR_HIST_EN
    ,
    input  logic [2:0]         hist_idx,
    output logic [AW-1:0]      hist_addr,
    output logic [DW-1:0]      hist_data
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_FAIL = 3'd3;
    localparam logic [2:0] S_TMO  = 3'd4;

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CMAX    = '1;

    logic [2:0]      state, st_nx;
    logic [CW-1:0]   cyc_nx, wc_nx, cyc_inc;
    logic [IW-1:0]   ptr, ptr_nx, mi_nx;
    logic [NSIG-1:0] hit;
    logic            wr;

    logic            any_hit;
    logic [IW-1:0]   low_idx;
    logic            cur_ok, nxt_ok, fl_ok;
    logic [IW-1:0]   cur, nxt, fl_idx;

    // A write counts only in RUN, never on the arming cycle, never when X
    assign wr = (state == S_RUN) && !start && ((|memwrite) === 1'b1);

    // Full-width signature compare; unknown inputs resolve to no hit
    always_comb begin
        hit = '0;
        for (int i = 0; i < NSIG; i++) begin
            hit[i] = ((sig_en[i]
                     & (dataadr   == sig_addr[i*AW +: AW])
                     & (writedata == sig_data[i*DW +: DW])) === 1'b1);
        end
    end

    // Lowest hit index for unordered mode
    always_comb begin
        any_hit = 1'b0;
        low_idx = '0;
        for (int i = 0; i < NSIG; i++) begin
            if (!any_hit && hit[i]) begin
                any_hit = 1'b1;
                low_idx = IW'(i);
            end
        end
    end

    // Ordered mode: current slot, slot after it, and out-of-order hit
    always_comb begin
        cur_ok = 1'b0;
        cur    = '0;
        nxt_ok = 1'b0;
        nxt    = '0;
        fl_ok  = 1'b0;
        fl_idx = '0;
        for (int i = 0; i < NSIG; i++) begin
            if (!cur_ok && sig_en[i] && i >= int'(ptr)) begin
                cur_ok = 1'b1;
                cur    = IW'(i);
            end
        end
        for (int i = 0; i < NSIG; i++) begin
            if (cur_ok && !nxt_ok && sig_en[i] && i > int'(cur)) begin
                nxt_ok = 1'b1;
                nxt    = IW'(i);
            end
            if (cur_ok && !fl_ok && hit[i] && i > int'(cur)) begin
                fl_ok  = 1'b1;
                fl_idx = IW'(i);
            end
        end
    end

    // Next-state, counters and match bookkeeping
    always_comb begin
        st_nx   = state;
        cyc_nx  = cycles;
        wc_nx   = wr_count;
        ptr_nx  = ptr;
        mi_nx   = match_idx;
        cyc_inc = (cycles == CMAX) ? cycles : cycles + 1'b1;
        if (start) begin
            st_nx  = S_RUN;
            cyc_nx = '0;
            wc_nx  = '0;
            ptr_nx = '0;
            mi_nx  = '0;
        end else if (state == S_RUN) begin
            cyc_nx = cyc_inc;
            if (wr) begin
                wc_nx = (wr_count == CMAX) ? wr_count : wr_count + 1'b1;
                if (ORDERED == 0) begin
                    if (any_hit) begin
                        st_nx = S_PASS;
                        mi_nx = low_idx;
                    end
                end else begin
                    if (cur_ok && hit[cur]) begin
                        if (nxt_ok) begin
                            ptr_nx = nxt;
                        end else begin
                            st_nx = S_PASS;
                            mi_nx = cur;
                        end
                    end else if (fl_ok) begin
                        st_nx = S_FAIL;
                        mi_nx = fl_idx;
                    end
                end
            end
            // A match on the final cycle takes precedence over timeout
            if (st_nx == S_RUN && cyc_inc >= TO_LAST) begin
                st_nx = S_TMO;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cycles    <= '0;
            wr_count  <= '0;
            ptr       <= '0;
            match_idx <= '0;
        end else begin
            state     <= st_nx;
            cycles    <= cyc_nx;
            wr_count  <= wc_nx;
            ptr       <= ptr_nx;
            match_idx <= mi_nx;
        end
    end

    assign busy    = (state == S_RUN);
    assign pass    = (state == S_PASS);
    assign fail    = (state == S_FAIL);
    assign timeout = (state == S_TMO);
    assign done    = pass | fail | timeout;

`ifdef MEM_WRITE_MONITOR_HIST_EN
    logic [AW-1:0] h_addr [8];
    logic [DW-1:0] h_data [8];
    logic [2:0]    h_wp;
    logic [2:0]    h_rd;

    // Circular history of writes seen in RUN, cleared on every arm
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_wp <= '0;
            for (int i = 0; i < 8; i++) begin
                h_addr[i] <= '0;
                h_data[i] <= '0;
            end
        end else if (start) begin
            h_wp <= '0;
            for (int i = 0; i < 8; i++) begin
                h_addr[i] <= '0;
                h_data[i] <= '0;
            end
        end else if (wr) begin
            h_addr[h_wp] <= dataadr;
            h_data[h_wp] <= writedata;
            h_wp         <= h_wp + 3'd1;
        end
    end

    assign h_rd      = h_wp - 3'd1 - hist_idx;
    assign hist_addr = h_addr[h_rd];
    assign hist_data = h_data[h_rd];
`endif

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
Synthesizable, parametrised pass/fail monitor for the 64-bit MIPS core's data-memory write port; it replaces ad-hoc bench checks with a reusable block.
- Compares each memory write against a table of NSIG (address, data) signatures.
- Enforces a cycle timeout.
- Reports pass, fail, or timeout with match index and counters.
- Sits beside `top`, snooping memwrite/dataadr/writedata; usable in simulation and on FPGA (status to LEDs/UART).

Parameters:
- AW, 64, dataadr width
- DW, 64, writedata width
- NSIG, 4, number of signature slots (≥1)
- CW, 10, width of cycle and write counters
- TIMEOUT, 512, cycles in RUN before timeout (1..2^CW-1)
- ORDERED, 0, 0 = any enabled signature passes; 1 = signatures must be hit in index order

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  single-cycle pulse; arms/re-arms the monitor
- memwrite  in  2  write strobe; any nonzero value = write this cycle
- dataadr  in  AW  write address
- writedata  in  DW  write data
- sig_addr  in  NSIG*AW  signature addresses, slot i at [i*AW +: AW]
- sig_data  in  NSIG*DW  signature data, same packing
- sig_en  in  NSIG  slot enable mask
- busy  out  1  state == RUN
- done  out  1  in PASS, FAIL or TMO
- pass  out  1  state == PASS
- fail  out  1  state == FAIL (ORDERED only)
- timeout  out  1  state == TMO
- match_idx  out  clog2(NSIG) (min 1)  slot that caused PASS/FAIL
- cycles  out  CW  cycles spent in RUN, saturating
- wr_count  out  CW  writes seen in RUN, saturating

Behaviour:
- Reset (reset=0, async):
  - state = IDLE.
  - All outputs 0, ptr = 0.
  - Legal at any time, including mid-RUN.
- States IDLE, RUN, PASS, FAIL, TMO.
  - IDLE --start--> RUN.
  - RUN --match--> PASS/FAIL.
  - RUN --cycles == TIMEOUT-1, no match--> TMO.
  - Terminal states hold until start.
- start in any state (IDLE, RUN or terminal): cycles, wr_count, ptr and match_idx cleared; next state RUN.
  - A write in the same cycle as start is ignored.
- In RUN, per rising edge:
  - cycles += 1 (saturate at all-ones).
  - If memwrite != 0: wr_count += 1 (saturate) and the write is compared.
- Hit[i] = sig_en[i] & dataadr == sig_addr[i] & writedata == sig_data[i], full-width compare. X/Z inputs never hit.
- ORDERED=0: any hit → PASS; match_idx = lowest hit index.
- ORDERED=1, pointer ptr over enabled slots:
  - hit[ptr] → ptr advances to the next enabled slot.
  - If no enabled slot remains → PASS, match_idx = ptr.
  - Hit on any other enabled slot (no hit on ptr) → FAIL, match_idx = lowest such index.
  - Repeat hit on an already-consumed slot is ignored.
  - Non-matching writes are ignored in both modes.
- Latency: outputs are registered; status reflects a write one cycle after the edge that sampled it.
- Same cycle match and timeout: match wins.
- sig_en all zero: only TMO is reachable.
- sig_* must be stable while busy; changes take effect on the next compare.
- cycles and wr_count freeze in terminal states.

Optional Feature:
Macro MEM_WRITE_MONITOR_HIST_EN.
- Defined:
  - Adds an 8-entry circular history of the last writes seen in RUN (address + data).
  - Extra ports: hist_idx in 3 (0 = newest), hist_addr out AW, hist_data out DW (combinational read).
  - Write pointer wraps 7→0; entries older than 8 are overwritten.
  - Unwritten entries read 0.
  - Cleared by reset and by start.
- Undefined: no history storage and no extra ports; all other behaviour identical.

Test Plan:
1. ORDERED=0; sig0=(84,7), sig1=(128,7), sig2=(80,1), sig_en=0111. Pulse start, then writes (80,0), then (84,7) → pass=1 and match_idx=0 one cycle after the second write; wr_count=2.
2. ORDERED=0; same table. Start with no writes → timeout=1, cycles=511 (TIMEOUT-1); pass=0.
3. ORDERED=1; sig0=(80,1), sig1=(84,7), sig_en=0011. Write (84,7) first → fail=1, match_idx=1. Restart, write (80,1) then (84,7) → pass=1, match_idx=1.
4. Same-cycle event: write (84,7) on the cycle where cycles reaches 511 → pass=1, timeout=0.
5. Reset mid-RUN (reset=0 for 3 cycles at cycle 100) → all outputs 0 immediately, without waiting for a clock edge. After release, start re-arms with cycles counting from 0.
6. With MEM_WRITE_MONITOR_HIST_EN: 10 non-matching writes to addr 0..9 → hist_idx=0 reads addr 9; hist_idx=7 reads addr 2.
